// File: rtl/uart_link_ctrl.sv
// Link controller between UART receiver and transmitter: SYN/ACK handshake, echo of received
// bytes through a small FIFO, EOT close with ACK, and an inactivity timeout.
module uart_link_ctrl #(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned TIMEOUT_CLKS = 1250000,
    parameter logic [7:0]  SYN_BYTE     = 8'h16,
    parameter logic [7:0]  ACK_BYTE     = 8'h06,
    parameter logic [7:0]  EOT_BYTE     = 8'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_dv,
    input  logic [7:0] rx_byte,
    input  logic       tx_busy,
    output logic       tx_dv,
    output logic [7:0] tx_byte,
    output logic       link_up,
    output logic       overflow
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [PtrW-1:0] PtrOne      = 1;
    localparam logic [CntW-1:0] CntOne      = 1;
    localparam logic [CntW-1:0] CntFull     = CntW'(FIFO_DEPTH);
    localparam logic [23:0]     TimeoutLast = 24'(TIMEOUT_CLKS - 1);
    localparam logic [23:0]     TimeoutMax  = 24'hFF_FFFF;

    localparam logic [1:0] IDLE          = 2'd0;
    localparam logic [1:0] SEND_ACK_OPEN = 2'd1;
    localparam logic [1:0] LINKED        = 2'd2;
    localparam logic [1:0] CLOSE         = 2'd3;

    logic [1:0]      stateQ, stateD;
    logic [7:0]      fifoMem [FIFO_DEPTH];
    logic [PtrW-1:0] wrPtr, rdPtr;
    logic [CntW-1:0] fifoCount;
    logic [23:0]     timeoutCnt;
    logic            holdoffQ;
    logic [7:0]      txByteQ;
    logic            linkUpQ;
    logic            overflowQ;

    logic fifoEmpty, fifoFull, txFree, timeoutHit;
    logic push, pop, issueAck, flush, pushAccepted, dropped;

    assign fifoEmpty = (fifoCount == '0);
    assign fifoFull  = (fifoCount == CntFull);
    // Holdoff masks the cycle after an issue, before the transmitter has raised busy.
    assign txFree    = !tx_busy && !holdoffQ;
    assign timeoutHit = (stateQ == LINKED) && !rx_dv && (timeoutCnt >= TimeoutLast);

    always_comb begin
        stateD   = stateQ;
        push     = 1'b0;
        pop      = 1'b0;
        issueAck = 1'b0;
        flush    = 1'b0;
        case (stateQ)
            IDLE: begin
                if (rx_dv && rx_byte == SYN_BYTE) stateD = SEND_ACK_OPEN;
            end
            SEND_ACK_OPEN: begin
                if (txFree) begin
                    issueAck = 1'b1;
                    stateD   = LINKED;
                end
            end
            LINKED: begin
                if (timeoutHit) begin
                    flush  = 1'b1;
                    stateD = IDLE;
                end else begin
                    if (!fifoEmpty && txFree) pop = 1'b1;
                    if (rx_dv) begin
                        if (rx_byte == EOT_BYTE) stateD = CLOSE;
                        else                     push   = 1'b1;
                    end
                end
            end
            CLOSE: begin
                if (txFree) begin
                    if (!fifoEmpty) begin
                        pop = 1'b1;
                    end else begin
                        issueAck = 1'b1;
                        stateD   = IDLE;
                    end
                end
            end
            default: stateD = IDLE;
        endcase
    end

    assign pushAccepted = push && (!fifoFull || pop);
    assign dropped      = push && fifoFull && !pop;

    assign tx_dv    = pop || issueAck;
    assign tx_byte  = pop ? fifoMem[rdPtr] : (issueAck ? ACK_BYTE : txByteQ);
    assign link_up  = linkUpQ;
    assign overflow = overflowQ;

    always_ff @(posedge clk) begin
        if (pushAccepted) fifoMem[wrPtr] <= rx_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ     <= IDLE;
            wrPtr      <= '0;
            rdPtr      <= '0;
            fifoCount  <= '0;
            timeoutCnt <= '0;
            holdoffQ   <= 1'b0;
            txByteQ    <= 8'h00;
            linkUpQ    <= 1'b0;
            overflowQ  <= 1'b0;
        end else begin
            stateQ   <= stateD;
            holdoffQ <= tx_dv;
            linkUpQ  <= (stateD == LINKED) || (stateD == CLOSE);
            if (tx_dv) txByteQ <= tx_byte;

            if (stateD == SEND_ACK_OPEN && stateQ != SEND_ACK_OPEN) overflowQ <= 1'b0;
            else if (dropped)                                       overflowQ <= 1'b1;

            if (flush) begin
                wrPtr     <= '0;
                rdPtr     <= '0;
                fifoCount <= '0;
            end else begin
                if (pushAccepted) wrPtr <= wrPtr + PtrOne;
                if (pop)          rdPtr <= rdPtr + PtrOne;
                if (pushAccepted && !pop)      fifoCount <= fifoCount + CntOne;
                else if (!pushAccepted && pop) fifoCount <= fifoCount - CntOne;
            end

            if (stateQ != LINKED || stateD != LINKED || rx_dv) timeoutCnt <= '0;
            else if (timeoutCnt != TimeoutMax)                 timeoutCnt <= timeoutCnt + 24'd1;
        end
    end

endmodule
